// File: rtl/lsq_mem_ctrl.sv
// rtl/lsq_mem_ctrl.sv - in-order LSQ-to-data-memory sequencer with completion port
//
// Buffers issued memory ops in a FIFO and runs one memory access at a time
// through a req/gnt/rvalid handshake. Forwarded loads bypass memory but still
// complete in order.
//
// Ports:
//   clk, rstn                         clock, async active-low reset
//   pcOut, addressOut, Data_out       issued op fields
//   loadStore, already_found          op is store / load already forwarded
//   no_issue                          low = push request this cycle
//   flush                             squash buffered and in-flight ops
//   mem_req, mem_we, mem_addr,
//   mem_wdata                         registered memory request
//   mem_gnt, mem_rvalid, mem_rdata    memory grant and load return
//   cmp_valid, cmp_pc, cmp_data,
//   cmp_is_store                      registered one-cycle completion
//   lsq_stall, count                  FIFO full / occupancy (combinational)
//   err_overflow, err_timeout         sticky error flags
module lsq_mem_ctrl #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [31:0]                pcOut,
    input  logic [31:0]                addressOut,
    input  logic [31:0]                Data_out,
    input  logic                       loadStore,
    input  logic                       already_found,
    input  logic                       no_issue,
    input  logic                       flush,
    output logic                       mem_req,
    output logic                       mem_we,
    output logic [31:0]                mem_addr,
    output logic [31:0]                mem_wdata,
    input  logic                       mem_gnt,
    input  logic                       mem_rvalid,
    input  logic [31:0]                mem_rdata,
    output logic                       cmp_valid,
    output logic [31:0]                cmp_pc,
    output logic [31:0]                cmp_data,
    output logic                       cmp_is_store,
    output logic                       lsq_stall,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       err_overflow,
    output logic                       err_timeout
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int TW = $clog2(TIMEOUT+1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

    state_t        state, state_n;
    logic [31:0]   pc_q   [DEPTH];
    logic [31:0]   addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic          st_q   [DEPTH];
    logic          fwd_q  [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] cnt;
    logic [TW-1:0] wcnt, wcnt_n;
    logic          full, empty, push, pop, ovf_set, tmo_set;
    logic          req_n, we_n, cv_n, cst_n;
    logic [31:0]   addr_n, wdata_n, cpc_n, cdata_n;

    assign full      = (cnt == CW'(DEPTH));
    assign empty     = (cnt == '0);
    assign lsq_stall = full;
    assign count     = cnt;
    // Flush discards a same-cycle push, so it neither enqueues nor overflows.
    assign push      = !no_issue && !full && !flush;
    assign ovf_set   = !no_issue && full && !flush;

    always_ff @(posedge clk) begin
        if (push) begin
            pc_q[wr_ptr]   <= pcOut;
            addr_q[wr_ptr] <= addressOut;
            data_q[wr_ptr] <= Data_out;
            st_q[wr_ptr]   <= loadStore;
            fwd_q[wr_ptr]  <= already_found;
        end
    end

    always_comb begin
        state_n = state;
        req_n   = mem_req;
        we_n    = mem_we;
        addr_n  = mem_addr;
        wdata_n = mem_wdata;
        cv_n    = 1'b0;
        cpc_n   = cmp_pc;
        cdata_n = cmp_data;
        cst_n   = cmp_is_store;
        pop     = 1'b0;
        wcnt_n  = wcnt;
        tmo_set = 1'b0;
        if (flush) begin
            req_n = 1'b0;
            we_n  = 1'b0;
            if (state == REQ)  state_n = IDLE;
            if (state == WAIT) state_n = DRAIN;
        end else begin
            case (state)
                IDLE: if (!empty) begin
                    if (fwd_q[rd_ptr] && !st_q[rd_ptr]) begin
                        cv_n    = 1'b1;
                        cpc_n   = pc_q[rd_ptr];
                        cdata_n = data_q[rd_ptr];
                        cst_n   = 1'b0;
                        pop     = 1'b1;
                    end else begin
                        req_n   = 1'b1;
                        we_n    = st_q[rd_ptr];
                        addr_n  = addr_q[rd_ptr];
                        wdata_n = data_q[rd_ptr];
                        state_n = REQ;
                    end
                end
                REQ: if (mem_gnt) begin
                    req_n = 1'b0;
                    we_n  = 1'b0;
                    if (st_q[rd_ptr]) begin
                        cv_n    = 1'b1;
                        cpc_n   = pc_q[rd_ptr];
                        cdata_n = '0;
                        cst_n   = 1'b1;
                        pop     = 1'b1;
                        state_n = IDLE;
                    end else begin
                        wcnt_n  = '0;
                        state_n = WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        cv_n    = 1'b1;
                        cpc_n   = pc_q[rd_ptr];
                        cdata_n = mem_rdata;
                        cst_n   = 1'b0;
                        pop     = 1'b1;
                        state_n = IDLE;
                    end else if (wcnt == TW'(TIMEOUT-1)) begin
                        // TIMEOUT-th edge in WAIT without data: force completion
                        // and swallow the late return in DRAIN.
                        cv_n    = 1'b1;
                        cpc_n   = pc_q[rd_ptr];
                        cdata_n = '0;
                        cst_n   = 1'b0;
                        pop     = 1'b1;
                        tmo_set = 1'b1;
                        state_n = DRAIN;
                    end else begin
                        wcnt_n = wcnt + 1'b1;
                    end
                end
                DRAIN: if (mem_rvalid) state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            cnt          <= '0;
            wcnt         <= '0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            cmp_valid    <= 1'b0;
            cmp_pc       <= '0;
            cmp_data     <= '0;
            cmp_is_store <= 1'b0;
            err_overflow <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            state        <= state_n;
            wcnt         <= wcnt_n;
            mem_req      <= req_n;
            mem_we       <= we_n;
            mem_addr     <= addr_n;
            mem_wdata    <= wdata_n;
            cmp_valid    <= cv_n;
            cmp_pc       <= cpc_n;
            cmp_data     <= cdata_n;
            cmp_is_store <= cst_n;
            if (ovf_set) err_overflow <= 1'b1;
            if (tmo_set) err_timeout  <= 1'b1;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                cnt <= cnt + CW'(push) - CW'(pop);
            end
        end
    end
endmodule

// File: doc/lsq_mem_ctrl.md
# lsq_mem_ctrl

Sequencer between the load-store queue issue port and the single-port data memory. It buffers issued memory operations in an in-order FIFO and drives one memory access at a time through a request/grant/return handshake. Every operation then leaves through a single completion port toward the ROB/CDB. Loads already satisfied by store forwarding inside the LSQ skip the memory but still complete in program order.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2.
- TIMEOUT, 15: maximum cycles spent in WAIT before a forced completion.

- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous, active-low reset.
- pcOut / addressOut / Data_out  in  32 each  issued op: PC, effective address, store data or forwarded load data.
- loadStore  in  1  0 = load, 1 = store.
- already_found  in  1  load data was forwarded inside the LSQ.
- no_issue  in  1  0 = valid issue this cycle (push request).
- flush  in  1  squash all buffered and in-flight ops.
- mem_req  out  1  memory request, registered.
- mem_we  out  1  1 = write.
- mem_addr / mem_wdata  out  32  request address and write data.
- mem_gnt  in  1  memory accepts the request this cycle.
- mem_rvalid / mem_rdata  in  1 / 32  load return.
- cmp_valid  out  1  one-cycle completion pulse.
- cmp_pc / cmp_data  out  32  completed PC; load data (0 for stores).
- cmp_is_store  out  1  completion is a store.
- lsq_stall  out  1  FIFO full; upstream must not issue.
- count  out  $clog2(DEPTH+1)  FIFO occupancy.
- err_overflow / err_timeout  out  1  sticky error flags; cleared only by reset.

## Operation
- FIFO entry fields: {pc, addr, data, st, fwd}.
- Push: when no_issue == 0 and the FIFO is not full.
  - If no_issue == 0 while full, the op is dropped and err_overflow is set.
- Pop: on completion of the head entry only. Push and pop may occur in the same cycle, and count stays unchanged.
- Pointers are log2(DEPTH)-bit and wrap naturally. Full/empty is decided from count.
- FSM states: IDLE, REQ, WAIT, DRAIN.
  - IDLE, FIFO empty: stay in IDLE.
  - IDLE, head is a forwarded load (fwd & ~st): cmp_valid ← 1 with head pc/data, pop, stay in IDLE.
  - IDLE, any other head: mem_req ← 1, mem_we ← st, and mem_addr/mem_wdata ← head fields; go to REQ.
  - REQ, mem_gnt low: hold all request outputs stable.
  - REQ, mem_gnt high, store: mem_req ← 0, complete with cmp_is_store = 1 and cmp_data = 0, pop, go to IDLE.
  - REQ, mem_gnt high, load: mem_req ← 0, clear the wait counter, go to WAIT.
  - WAIT, mem_rvalid high: complete with cmp_data = mem_rdata, pop, go to IDLE.
  - WAIT, counter reaches TIMEOUT: complete with cmp_data = 0, set err_timeout, pop, go to DRAIN.
  - DRAIN: discard the next mem_rvalid, then go to IDLE. DRAIN accepts no new memory request.
- mem_rvalid outside WAIT or DRAIN is ignored.
- Flush, highest priority:
  - FIFO emptied; count ← 0.
  - A push in the same cycle is discarded.
  - cmp_valid ← 0 and mem_req ← 0.
  - State transition: REQ → IDLE (the request is withdrawn even if mem_gnt is high that cycle); WAIT → DRAIN; DRAIN stays in DRAIN; IDLE stays in IDLE.
- Exactly one completion per non-flushed, non-dropped op, in push order.

## Timing
- Reset values: all outputs 0; state IDLE; FIFO empty; error flags cleared. Reset asserted mid-operation aborts everything immediately.
- lsq_stall and count are combinational from FIFO state. All other outputs are registered.
- An op pushed at edge N is visible at the head from cycle N+1.
- Forwarded load at an empty FIFO: pushed at edge N, cmp_valid at edge N+1.
- Store: mem_req at N+1, grant at the first edge with mem_gnt high, cmp_valid from that edge.
- Load: cmp_valid asserts at the edge where mem_rvalid is sampled in WAIT. Minimum load latency is 3 edges from push.
- Back-to-back forwarded loads complete at one per cycle.
- cmp_valid is high for exactly one cycle and has no backpressure.

## Test plan
- Store (pc 0x10, addr 0x100, data 0xDEAD), mem_gnt tied high: mem_req/mem_we = 1 for one cycle with addr 0x100 and wdata 0xDEAD; then cmp_valid, cmp_pc 0x10, cmp_is_store 1.
- Load (pc 0x14, addr 0x100) with mem_rvalid two cycles after grant carrying rdata 0xDEAD: exactly one cmp_valid with data 0xDEAD; mem_req low during WAIT.
- Forwarded load (pc 0x18, data 0x55, already_found 1) queued behind a load still in WAIT: no memory request for pc 0x18; completion order 0x14 then 0x18.
- Push 5 ops with mem_gnt held low (DEPTH 4): lsq_stall high after 4 pushes, count = 4, 5th op dropped and err_overflow = 1; after mem_gnt rises, exactly 4 completions in order.
- Flush while in WAIT: count → 0; the subsequent mem_rvalid is discarded (no cmp_valid); the next pushed store issues normally.
- Load whose rvalid never arrives: at cycle TIMEOUT = 15, cmp_valid with data 0 and err_timeout = 1; a late rvalid is discarded; rstn low clears all outputs asynchronously.
